// File: rtl/mul_pkg.sv
// Shared types and elaboration helpers for the iterative shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest operand the magnitude helper can carry.
    localparam int MAX_W = 64;

    function automatic int n_steps(input int width, input int bpc);
        return width / bpc;
    endfunction

    function automatic int cnt_w(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

    // Two's-complement negate when requested; callers truncate to operand width,
    // so -2^(W-1) comes back as the unsigned magnitude 2^(W-1).
    function automatic logic [MAX_W-1:0] mag_of(input logic [MAX_W-1:0] x, input logic neg);
        return neg ? (~x + MAX_W'(1)) : x;
    endfunction

endpackage

// File: rtl/mul_step.sv
// One WIDTH x BPC partial-product slice: AND array rows summed with their bit weights.
module mul_step #(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic [WIDTH-1:0]     mcand,
    input  logic [BPC-1:0]       mplier,
    output logic [WIDTH+BPC-1:0] pp
);

    logic [WIDTH-1:0] row [BPC];

    for (genvar j = 0; j < BPC; j++) begin : g_row
        assign row[j] = mcand & {WIDTH{mplier[j]}};
    end

    always_comb begin
        pp = '0;
        for (int j = 0; j < BPC; j++) begin
            pp = pp + ((WIDTH+BPC)'(row[j]) << j);
        end
    end

endmodule

// File: rtl/mul_iter_param.sv
// Iterative shift-add multiplier retiring BPC multiplier bits per clock,
// with sign-magnitude handling and valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// BUSY  | accumulating partial products, one BPC slice per clock
// DONE  | product held on y with out_valid until out_ready
module mul_iter_param
    import mul_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int BPC       = 1,
    parameter int SIGNED_EN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] y,
    output logic               busy
);

    localparam int N_STEPS = n_steps(WIDTH, BPC);
    localparam int CNT_W   = cnt_w(N_STEPS);
    localparam int YW      = 2 * WIDTH;

    if ((BPC < 1) || (WIDTH < 2) || (WIDTH > MAX_W) || ((WIDTH % BPC) != 0)) begin : g_bad_param
        $error("mul_iter_param: need 2 <= WIDTH <= 64 and BPC dividing WIDTH");
    end

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic [YW-1:0]      acc_q, acc_d;
    logic [YW-1:0]      y_q, y_d;
    logic [WIDTH-1:0]   mag_a_q, mag_a_d;
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;

    logic               sgn;
    logic [WIDTH+BPC-1:0] pp;
    logic [YW-1:0]      acc_step;

    assign sgn = signed_mode && (SIGNED_EN != 0);

    mul_step #(
        .WIDTH (WIDTH),
        .BPC   (BPC)
    ) u_step (
        .mcand  (mag_a_q),
        .mplier (mag_b_q[BPC-1:0]),
        .pp     (pp)
    );

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        y_d      = y_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        acc_step = acc_q + (YW'(pp) << (int'(cnt_q) * BPC));

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d = BUSY;
                    mag_a_d = WIDTH'(mag_of(MAX_W'(a), sgn & a[WIDTH-1]));
                    mag_b_d = WIDTH'(mag_of(MAX_W'(b), sgn & b[WIDTH-1]));
                    neg_d   = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                acc_d   = acc_step;
                mag_b_d = mag_b_q >> BPC;
                cnt_d   = cnt_q + CNT_W'(1);
                // Last slice: fold the sign back in on the same edge as the final add.
                if (cnt_q == CNT_W'(N_STEPS - 1)) begin
                    state_d = DONE;
                    y_d     = neg_q ? -acc_step : acc_step;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            acc_q       <= '0;
            y_q         <= '0;
            mag_a_q     <= '0;
            mag_b_q     <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            acc_q       <= acc_d;
            y_q         <= y_d;
            mag_a_q     <= mag_a_d;
            mag_b_q     <= mag_b_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign y         = y_q;

endmodule

// File: tb/tb_mul_iter_param.sv
// Bench for mul_iter_param: directed vectors and corner sequences on two fixed
// configurations, plus randomized traffic on four more against an arithmetic model.
module tb_mul_iter_param;

    typedef longint unsigned u64_t;
    typedef longint          s64_t;

    typedef struct {
        int          dut;
        logic [15:0] a;
        logic [15:0] b;
        logic        sm;
        logic [31:0] y;
    } vec_t;

    localparam int R_PAIRS  = 2500;
    localparam int R_BUDGET = 60000;
    localparam int RW [4] = '{8, 12, 16, 8};
    localparam int RB [4] = '{1, 2, 4, 2};
    localparam int RS [4] = '{1, 1, 1, 0};

    logic clk = 1'b0;
    logic rst_n;
    logic rst8_n;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic u64_t model(input int w, input u64_t a, input u64_t b, input bit sgn);
        s64_t sa, sb;
        u64_t mask;
        mask = (u64_t'(1) << (2 * w)) - 1;
        sa = s64_t'(a);
        sb = s64_t'(b);
        if (sgn) begin
            if (a[w-1]) sa = sa - (s64_t'(1) << w);
            if (b[w-1]) sb = sb - (s64_t'(1) << w);
        end
        return u64_t'(sa * sb) & mask;
    endfunction

    // Directed DUT 8x8, one bit per clock.
    logic        iv8, ir8, sm8, ov8, or8, bz8;
    logic [7:0]  a8, b8;
    logic [15:0] y8;

    mul_iter_param #(.WIDTH(8), .BPC(1), .SIGNED_EN(1)) u_d8 (
        .clk(clk), .rst_n(rst8_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .y(y8), .busy(bz8)
    );

    // Directed DUT 16x16, four bits per clock.
    logic        iv16, ir16, sm16, ov16, or16, bz16;
    logic [15:0] a16, b16;
    logic [31:0] y16;

    mul_iter_param #(.WIDTH(16), .BPC(4), .SIGNED_EN(1)) u_d16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .signed_mode(sm16), .out_valid(ov16), .out_ready(or16), .y(y16), .busy(bz16)
    );

    function automatic logic get_ov(input int d);
        return (d == 0) ? ov8 : ov16;
    endfunction

    function automatic logic get_ir(input int d);
        return (d == 0) ? ir8 : ir16;
    endfunction

    function automatic logic [31:0] get_y(input int d);
        return (d == 0) ? {16'h0, y8} : y16;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        int n;
        n = (v.dut == 0) ? 8 : 4;
        @(negedge clk);
        if (v.dut == 0) begin
            a8 = v.a[7:0]; b8 = v.b[7:0]; sm8 = v.sm; iv8 = 1'b1; or8 = 1'b1;
        end else begin
            a16 = v.a; b16 = v.b; sm16 = v.sm; iv16 = 1'b1; or16 = 1'b1;
        end
        check({tag, "_in_ready"}, 64'(get_ir(v.dut)), 64'd1);
        @(negedge clk);
        iv8 = 1'b0; iv16 = 1'b0;
        lat = 0;
        while (!get_ov(v.dut) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(n));
        check({tag, "_y"}, 64'(get_y(v.dut)), 64'(v.y));
        @(negedge clk);
        check({tag, "_valid_pulse"}, 64'(get_ov(v.dut)), 64'd0);
        check({tag, "_ready_after"}, 64'(get_ir(v.dut)), 64'd1);
    endtask

    // Randomized configurations, each with its own model scoreboard.
    for (genvar g = 0; g < 4; g++) begin : g_rnd
        localparam int W  = RW[g];
        localparam int B  = RB[g];
        localparam int SE = RS[g];
        localparam int N  = W / B;

        logic             iv, ir, sm, ov, orr, bz;
        logic [W-1:0]     ra, rb;
        logic [2*W-1:0]   ry;

        mul_iter_param #(.WIDTH(W), .BPC(B), .SIGNED_EN(SE)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(ra), .b(rb),
            .signed_mode(sm), .out_valid(ov), .out_ready(orr), .y(ry), .busy(bz)
        );

        initial begin : rnd
            u64_t exp_q [$];
            int   acc_cyc [$];
            int   got;
            int   cyc;
            logic ov_prev;
            logic will_acc, will_fire;
            iv = 1'b0; orr = 1'b0; sm = 1'b0; ra = '0; rb = '0;
            got = 0; cyc = 0; ov_prev = 1'b0;
            @(posedge rst_n);
            while (got < R_PAIRS && cyc < R_BUDGET) begin
                @(negedge clk);
                cyc++;
                if (ov && !ov_prev) begin
                    if (acc_cyc.size() == 0) check($sformatf("rnd%0d_spurious_valid", g), 64'(acc_cyc.size()), 64'd1);
                    else check($sformatf("rnd%0d_latency", g), 64'(cyc - acc_cyc[0]), 64'(N + 1));
                end
                ov_prev = ov;
                iv  = ($urandom_range(0, 3) != 0);
                orr = ($urandom_range(0, 3) != 0);
                ra  = W'($urandom);
                rb  = W'($urandom);
                sm  = 1'($urandom_range(0, 1));
                will_acc  = iv & ir;
                will_fire = ov & orr;
                if (will_fire) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("rnd%0d_extra_output", g), 64'(exp_q.size()), 64'd1);
                    end else begin
                        check($sformatf("rnd%0d_y", g), 64'(ry), exp_q.pop_front());
                        void'(acc_cyc.pop_front());
                        got++;
                    end
                end
                if (will_acc) begin
                    check($sformatf("rnd%0d_one_in_flight", g), 64'(exp_q.size()), 64'd0);
                    exp_q.push_back(model(W, u64_t'(ra), u64_t'(rb), (sm == 1'b1) && (SE != 0)));
                    acc_cyc.push_back(cyc);
                end
            end
            check($sformatf("rnd%0d_outputs", g), 64'(got), 64'(R_PAIRS));
            check($sformatf("rnd%0d_leftover", g), 64'(exp_q.size()), 64'd0);
            iv  = 1'b0;
            orr = 1'b1;
            done_cnt++;
        end
    end

    vec_t vecs [9];

    initial begin
        int   lat;
        int   guard;
        vecs[0] = '{0, 16'h00FF, 16'h00FF, 1'b0, 32'h0000FE01};
        vecs[1] = '{0, 16'h0080, 16'h0080, 1'b1, 32'h00004000};
        vecs[2] = '{0, 16'h00FD, 16'h0005, 1'b1, 32'h0000FFF1};
        vecs[3] = '{0, 16'h00FD, 16'h0005, 1'b0, 32'h000004F1};
        vecs[4] = '{0, 16'h0000, 16'h00A5, 1'b1, 32'h00000000};
        vecs[5] = '{0, 16'h00FF, 16'h0001, 1'b1, 32'h0000FFFF};
        vecs[6] = '{1, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
        vecs[7] = '{1, 16'h8000, 16'h7FFF, 1'b1, 32'hC0008000};
        vecs[8] = '{1, 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001};

        rst_n = 1'b0; rst8_n = 1'b0;
        iv8 = 1'b0; or8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        iv16 = 1'b0; or16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(ir8), 64'd1);
        check("rst_out_valid", 64'(ov8), 64'd0);
        check("rst_busy", 64'(bz8), 64'd0);
        check("rst_y", 64'(y8), 64'd0);
        check("rst16_y", 64'(y16), 64'd0);
        rst_n = 1'b1; rst8_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result must hold while out_ready is low, new operands ignored.
        @(negedge clk);
        a8 = 8'd12; b8 = 8'd11; sm8 = 1'b0; iv8 = 1'b1; or8 = 1'b0;
        @(negedge clk);
        iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("bp_latency", 64'(lat), 64'd8);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_held", 64'(ov8), 64'd1);
            check("bp_y_held", 64'(y8), 64'd132);
            check("bp_in_ready_low", 64'(ir8), 64'd0);
            check("bp_busy", 64'(bz8), 64'd1);
            if (i == 2) begin
                a8 = 8'd3; b8 = 8'd3; iv8 = 1'b1;
            end else begin
                iv8 = 1'b0;
            end
            @(negedge clk);
        end
        check("bp_valid_end", 64'(ov8), 64'd1);
        check("bp_y_end", 64'(y8), 64'd132);
        or8 = 1'b1;
        @(negedge clk);
        check("bp_released_valid", 64'(ov8), 64'd0);
        check("bp_released_ready", 64'(ir8), 64'd1);
        check("bp_y_kept", 64'(y8), 64'd132);

        // Asynchronous reset while BUSY with cnt=3.
        a8 = 8'd200; b8 = 8'd3; sm8 = 1'b0; iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_busy", 64'(bz8), 64'd1);
        rst8_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 64'(ir8), 64'd1);
        check("mid_rst_out_valid", 64'(ov8), 64'd0);
        check("mid_rst_busy", 64'(bz8), 64'd0);
        check("mid_rst_y", 64'(y8), 64'd0);
        @(negedge clk);
        rst8_n = 1'b1;
        run_vec('{0, 16'd7, 16'd9, 1'b0, 32'd63}, "post_rst");

        guard = 0;
        while (done_cnt < 4 && guard < 90000) begin
            @(negedge clk);
            guard++;
        end
        if (done_cnt < 4) check("rnd_timeout", 64'(done_cnt), 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
